// File: rtl/mem_read_sequencer.sv
// mem_read_sequencer
//   Issues single reads to a read-only block memory and absorbs its read
//   latency. Two addressing modes:
//     manual (mode=0): re-reads whenever the switch address differs from the
//                      address of the word currently shown (and once after reset).
//     auto   (mode=1): steps through all addresses, one step per SCAN_DIV cycles.
//   Each capture produces registered data, its address tag and a one-cycle
//   valid pulse for the display formatter downstream.
//
// Parameters
//   DATA_W   memory word width
//   ADDR_W   address width (depth = 2**ADDR_W)
//   RD_LAT   BRAM read latency in cycles (1..4)
//   SCAN_DIV clock cycles between auto-scan steps (>= RD_LAT+3)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   ena        enable; low blocks new reads, an in-flight read still completes
//   mode       0 = manual (switch), 1 = auto-scan
//   switch     manual read address
//   mem_en     BRAM enable
//   mem_addr   BRAM address
//   mem_dout   BRAM read data
//   data_out   last captured word
//   data_addr  address of data_out
//   data_valid one-cycle pulse on each capture
//   busy       high while a read is in flight
//   hold       (only with MEM_READ_SEQ_HOLD_EN defined) freezes the readout:
//              no new reads, scan counter frozen, pending step dropped
//
// Optional feature macro: MEM_READ_SEQ_HOLD_EN

module mem_read_sequencer #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int RD_LAT   = 2,
  parameter int SCAN_DIV = 100000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              mode,
`ifdef MEM_READ_SEQ_HOLD_EN
  input  logic              hold,
`endif
  input  logic [ADDR_W-1:0] switch,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] data_addr,
  output logic              data_valid,
  output logic              busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  localparam int                SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [2:0]        WAIT_LOAD = 3'(RD_LAT - 1);

  logic [1:0]        state;
  logic [2:0]        wait_cnt;
  logic [SCAN_W-1:0] scan_cnt;
  logic              first_rd;
  logic              step_pend;

  logic              hold_act;
  logic              scan_run;
  logic              tick;
  logic              start;
  logic [ADDR_W-1:0] next_addr;

`ifdef MEM_READ_SEQ_HOLD_EN
  assign hold_act = hold;
`else
  assign hold_act = 1'b0;
`endif

  // The scan counter only runs in auto mode while enabled; gating the tick
  // the same way keeps a stale terminal count from being seen after a mode
  // or enable change.
  assign scan_run = mode && ena;
  assign tick     = scan_run && !hold_act && (scan_cnt == SCAN_LAST);

  // Read-start decision and target address, evaluated only in IDLE.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    start     = 1'b0;
    next_addr = switch;
    if (state == S_IDLE && ena && !hold_act) begin
      if (!mode) begin
        start     = first_rd || (switch != data_addr);
        next_addr = switch;
      end else begin
        start     = tick || step_pend;
        next_addr = first_rd ? '0 : data_addr + 1'b1;
      end
    end
  end

  // Scan divider: held at 0 outside auto mode, frozen (not cleared) by hold.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      scan_cnt <= '0;
    end else if (!scan_run) begin
      scan_cnt <= '0;
    end else if (!hold_act) begin
      scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 1'b1;
    end
  end

  // At most one scan step is remembered while a read is in flight; it is
  // consumed (or made irrelevant) as soon as the FSM is back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_pend <= 1'b0;
    end else if (hold_act || !scan_run || state == S_IDLE) begin
      step_pend <= 1'b0;
    end else if (tick) begin
      step_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      first_rd   <= 1'b1;
      mem_en     <= 1'b0;
      mem_addr   <= '0;
      data_out   <= '0;
      data_addr  <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_ISSUE;
            mem_addr <= next_addr;
            mem_en   <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_ISSUE: begin
          wait_cnt <= WAIT_LOAD;
          // With a single-cycle BRAM the data is already there next cycle.
          state    <= (RD_LAT == 1) ? S_CAPTURE : S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt <= 3'd1) state <= S_CAPTURE;
        end
        default: begin
          data_out   <= mem_dout;
          data_addr  <= mem_addr;
          data_valid <= 1'b1;
          first_rd   <= 1'b0;
          mem_en     <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_sequencer.sv
`timescale 1ns/1ps
module tb_mem_read_sequencer;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 3;
  localparam int RD_LAT   = 2;
  localparam int SCAN_DIV = 8;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ena = 1'b0;
  logic              mode = 1'b0;
  logic [ADDR_W-1:0] switch = '0;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] data_addr;
  logic              data_valid;
  logic              busy;
`ifdef MEM_READ_SEQ_HOLD_EN
  logic              hold = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  mem_read_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode),
`ifdef MEM_READ_SEQ_HOLD_EN
    .hold(hold),
`endif
    .switch(switch), .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .data_out(data_out), .data_addr(data_addr), .data_valid(data_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory contents and a registered BRAM with RD_LAT cycles of read latency.
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return 32'hA000_0000 + DATA_W'(a);
  endfunction

  logic [DATA_W-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    pipe[0] <= mem_en ? rom_word(mem_addr) : pipe[0];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_dout = pipe[RD_LAT-1];

  // Cycle counter and monitor: read starts, captures, enable activity.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int                iss_cyc[$];
  logic [ADDR_W-1:0] iss_addr[$];
  int                val_cyc[$];
  logic [ADDR_W-1:0] val_addr[$];
  logic [DATA_W-1:0] val_data[$];
  logic [ADDR_W-1:0] sw_hist [0:8191];
  logic              mem_en_d = 1'b0;
  int                en_cycles = 0;

  always @(negedge clk) begin
    sw_hist[cyc % 8192] = switch;
    if (mem_en) en_cycles++;
    if (mem_en && !mem_en_d) begin
      iss_cyc.push_back(cyc);
      iss_addr.push_back(mem_addr);
    end
    mem_en_d = mem_en;
    if (data_valid) begin
      val_cyc.push_back(cyc);
      val_addr.push_back(data_addr);
      val_data.push_back(data_out);
    end
  end

  task automatic clear_mon();
    iss_cyc.delete(); iss_addr.delete();
    val_cyc.delete(); val_addr.delete(); val_data.delete();
  endtask

  task automatic do_reset(input logic m, input logic e, input logic [ADDR_W-1:0] sw);
    rst = 1'b1; mode = m; ena = e; switch = sw;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_mon();
  endtask

  task automatic wait_issue(input int n_before, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (iss_cyc.size() > n_before) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_valid(input int n_before, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (val_cyc.size() > n_before) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1; ena = 1'b1; mode = 1'b0; switch = 3'd5;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({data_out, data_addr, data_valid, busy, mem_en, mem_addr} !== '0)
      $display("FAIL reset_values: got %h expected 0",
               {data_out, data_addr, data_valid, busy, mem_en, mem_addr});
    else n_pass++;
    rst = 1'b0;
    clear_mon();
    wait_valid(0, 20, ok);
    n_checks++;
    if (!ok) $display("FAIL reset_first_read_timeout: got no capture expected one");
    else n_pass++;
    repeat (15) @(negedge clk);
    #1;
    n_checks++;
    if (iss_cyc.size() !== 1 || val_cyc.size() !== 1)
      $display("FAIL reset_single_read: got %0d reads/%0d captures expected 1/1",
               iss_cyc.size(), val_cyc.size());
    else begin
      n_pass++;
      n_checks++;
      if (val_addr[0] !== 3'd5 || val_data[0] !== 32'hA000_0005)
        $display("FAIL reset_capture: got %0d/%h expected 5/a0000005", val_addr[0], val_data[0]);
      else n_pass++;
      n_checks++;
      if (val_cyc[0] - iss_cyc[0] !== RD_LAT + 1)
        $display("FAIL reset_latency: got %0d expected %0d", val_cyc[0] - iss_cyc[0], RD_LAT + 1);
      else n_pass++;
    end
  endtask

  task automatic test_manual_change();
    bit ok;
    do_reset(1'b0, 1'b1, 3'd5);
    wait_issue(0, 20, ok);
    @(posedge clk); #1 switch = 3'd2;   // lands in the WAIT cycle
    repeat (25) @(negedge clk);
    #1;
    n_checks++;
    if (!ok || val_cyc.size() !== 2 || iss_cyc.size() !== 2)
      $display("FAIL manual_change_count: got %0d captures expected 2", val_cyc.size());
    else begin
      n_pass++;
      n_checks++;
      if (val_addr[0] !== 3'd5 || val_data[0] !== rom_word(3'd5) ||
          val_addr[1] !== 3'd2 || val_data[1] !== rom_word(3'd2))
        $display("FAIL manual_change_data: got %0d:%h %0d:%h expected 5:a0000005 2:a0000002",
                 val_addr[0], val_data[0], val_addr[1], val_data[1]);
      else n_pass++;
      n_checks++;
      if (iss_cyc[1] <= val_cyc[0])
        $display("FAIL manual_change_gap: got issue %0d expected after %0d", iss_cyc[1], val_cyc[0]);
      else n_pass++;
    end
  endtask

  task automatic test_manual_random();
    logic [ADDR_W-1:0] exp_a;
    do_reset(1'b0, 1'b1, ADDR_W'($urandom_range(0, DEPTH - 1)));
    for (int s = 0; s < 30; s++) begin
      repeat ($urandom_range(1, 7)) @(posedge clk);
      #1 switch = ADDR_W'($urandom_range(0, DEPTH - 1));
    end
    repeat (15) @(negedge clk);
    #1;
    n_checks++;
    if (iss_cyc.size() !== val_cyc.size() || val_cyc.size() == 0)
      $display("FAIL rand_counts: got %0d reads %0d captures expected equal nonzero",
               iss_cyc.size(), val_cyc.size());
    else n_pass++;
    for (int i = 0; i < iss_cyc.size() && i < val_cyc.size(); i++) begin
      exp_a = sw_hist[(iss_cyc[i] - 1) % 8192];
      n_checks++;
      if (iss_addr[i] !== exp_a)
        $display("FAIL rand_issue_addr[%0d]: got %0d expected %0d", i, iss_addr[i], exp_a);
      else n_pass++;
      n_checks++;
      if (val_addr[i] !== iss_addr[i] || val_data[i] !== rom_word(iss_addr[i]) ||
          val_cyc[i] - iss_cyc[i] !== RD_LAT + 1)
        $display("FAIL rand_capture[%0d]: got %0d:%h@%0d expected %0d:%h@%0d", i,
                 val_addr[i], val_data[i], val_cyc[i] - iss_cyc[i],
                 iss_addr[i], rom_word(iss_addr[i]), RD_LAT + 1);
      else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (iss_addr[i] === val_addr[i-1])
          $display("FAIL rand_redundant_read[%0d]: got %0d expected a changed address", i, iss_addr[i]);
        else n_pass++;
      end
    end
    n_checks++;
    if (data_addr !== switch || data_out !== rom_word(switch))
      $display("FAIL rand_latest_wins: got %0d:%h expected %0d:%h",
               data_addr, data_out, switch, rom_word(switch));
    else n_pass++;
  endtask

  task automatic test_auto();
    bit ok;
    logic [ADDR_W-1:0] exp_a;
    do_reset(1'b1, 1'b1, 3'd0);
    wait_valid(9, 200, ok);
    n_checks++;
    if (!ok) $display("FAIL auto_count: got %0d captures expected 10", val_cyc.size());
    else begin
      n_pass++;
      for (int k = 0; k < 10; k++) begin
        exp_a = ADDR_W'(k % DEPTH);
        n_checks++;
        if (val_addr[k] !== exp_a || val_data[k] !== rom_word(exp_a))
          $display("FAIL auto_capture[%0d]: got %0d:%h expected %0d:%h",
                   k, val_addr[k], val_data[k], exp_a, rom_word(exp_a));
        else n_pass++;
        if (k > 0) begin
          n_checks++;
          if (val_cyc[k] - val_cyc[k-1] !== SCAN_DIV)
            $display("FAIL auto_period[%0d]: got %0d expected %0d",
                     k, val_cyc[k] - val_cyc[k-1], SCAN_DIV);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_mode_switch();
    bit ok1, ok2, ok3;
    logic [ADDR_W-1:0] r, s;
    r = ADDR_W'($urandom_range(0, DEPTH - 1));
    s = r + 3'd4;
    do_reset(1'b0, 1'b1, r);
    wait_issue(0, 20, ok1);
    @(posedge clk); #1 mode = 1'b1;     // change mode mid-read
    wait_valid(1, 40, ok2);
    @(posedge clk); #1 begin mode = 1'b0; switch = s; end
    wait_valid(2, 40, ok3);
    n_checks++;
    if (!(ok1 && ok2 && ok3))
      $display("FAIL mode_timeout: got %0d captures expected 3", val_cyc.size());
    else begin
      n_pass++;
      n_checks++;
      if (val_addr[0] !== r || val_addr[1] !== ADDR_W'(r + 3'd1) || val_addr[2] !== s)
        $display("FAIL mode_sequence: got %0d,%0d,%0d expected %0d,%0d,%0d",
                 val_addr[0], val_addr[1], val_addr[2], r, ADDR_W'(r + 3'd1), s);
      else n_pass++;
      n_checks++;
      if (val_data[2] !== rom_word(s))
        $display("FAIL mode_data: got %h expected %h", val_data[2], rom_word(s));
      else n_pass++;
    end
  endtask

  task automatic test_ena_low();
    bit ok1, ok2, ok3;
    do_reset(1'b0, 1'b1, 3'd3);
    wait_issue(0, 20, ok1);
    @(posedge clk); #1 begin ena = 1'b0; switch = 3'd6; end
    wait_valid(0, 10, ok2);
    n_checks++;
    if (!(ok1 && ok2) || val_addr[0] !== 3'd3)
      $display("FAIL ena_inflight: got %0d captures expected read of 3 to complete", val_cyc.size());
    else n_pass++;
    en_cycles = 0;
    repeat (50) @(posedge clk);
    #1;
    n_checks++;
    if (en_cycles !== 0 || val_cyc.size() !== 1)
      $display("FAIL ena_blocked: got %0d mem_en cycles expected 0", en_cycles);
    else n_pass++;
    ena = 1'b1;
    wait_valid(1, 15, ok3);
    n_checks++;
    if (!ok3 || val_addr[1] !== 3'd6 || val_data[1] !== rom_word(3'd6))
      $display("FAIL ena_resume: got %0d captures expected read of 6", val_cyc.size());
    else n_pass++;
  endtask

  task automatic test_async_rst();
    bit ok1, ok2, ok3;
    int nv;
    do_reset(1'b0, 1'b1, 3'd1);
    wait_valid(0, 20, ok1);
    @(posedge clk); #1 switch = 3'd4;
    wait_issue(1, 20, ok2);
    @(posedge clk);                     // start of the WAIT cycle
    #3 begin rst = 1'b1; switch = 3'd0; end
    #1;
    n_checks++;
    if ({data_out, data_addr, data_valid, busy, mem_en, mem_addr} !== '0)
      $display("FAIL async_rst_values: got %h expected 0",
               {data_out, data_addr, data_valid, busy, mem_en, mem_addr});
    else n_pass++;
    nv = val_cyc.size();
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (!(ok1 && ok2) || nv !== 1 || val_cyc.size() !== 1)
      $display("FAIL async_rst_discard: got %0d captures expected 1", val_cyc.size());
    else n_pass++;
    rst = 1'b0;
    wait_valid(1, 20, ok3);
    n_checks++;
    if (!ok3 || val_addr[1] !== 3'd0 || val_data[1] !== rom_word(3'd0))
      $display("FAIL async_rst_fresh_read: got %0d captures expected read of 0", val_cyc.size());
    else n_pass++;
  endtask

`ifdef MEM_READ_SEQ_HOLD_EN
  task automatic test_hold();
    bit ok1, ok2;
    int nv;
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
    do_reset(1'b1, 1'b1, 3'd0);
    wait_valid(1, 60, ok1);
    @(posedge clk); #1 hold = 1'b1;
    d = data_out; a = data_addr; nv = val_cyc.size();
    en_cycles = 0;
    repeat (40) @(posedge clk);
    #1;
    n_checks++;
    if (!ok1 || en_cycles !== 0 || data_out !== d || val_cyc.size() !== nv)
      $display("FAIL hold_freeze: got %0d mem_en cycles data %h expected 0 and %h",
               en_cycles, data_out, d);
    else n_pass++;
    hold = 1'b0;
    wait_valid(nv, 40, ok2);
    n_checks++;
    if (!ok2 || val_addr[nv] !== ADDR_W'(a + 3'd1))
      $display("FAIL hold_resume: got %0d captures expected next address %0d",
               val_cyc.size(), ADDR_W'(a + 3'd1));
    else n_pass++;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    test_reset();
    test_manual_change();
    test_manual_random();
    test_auto();
    test_mode_switch();
    test_ena_low();
    test_async_rst();
`ifdef MEM_READ_SEQ_HOLD_EN
    test_hold();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_read_sequencer.md
Name: mem_read_sequencer

Overview:
- Parametrised successor to the switch-addressed BRAM readout used in the seven-segment project.
- Issues single reads to a read-only block memory of any width and depth, and absorbs the configurable BRAM read latency.
- Two addressing modes: manual (switch address, re-read on change) and auto-scan (timed walk through all addresses).
- Registered data, address tag and one-cycle valid pulse feed the display formatter downstream.

Parameters:
- DATA_W, 32, memory word width.
- ADDR_W, 3, address width; depth = 2**ADDR_W.
- RD_LAT, 2, BRAM read latency in cycles (1..4). mem_dout is valid RD_LAT rising edges after the ISSUE edge.
- SCAN_DIV, 100000000, clock cycles between auto-scan steps (>=RD_LAT+3).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- ena  input  1  enable; low blocks new reads, an in-flight read completes
- mode  input  1  0 = manual (switch), 1 = auto-scan
- switch  input  ADDR_W  manual read address
- mem_en  output  1  BRAM enable
- mem_addr  output  ADDR_W  BRAM address
- mem_dout  input  DATA_W  BRAM read data
- data_out  output  DATA_W  last captured word
- data_addr  output  ADDR_W  address of data_out
- data_valid  output  1  one-cycle pulse on each capture
- busy  output  1  high while a read is in flight

Behaviour:
- Reset (async assert, sync release) drives these values:
  - data_out=0, data_addr=0, data_valid=0, busy=0
  - mem_en=0, mem_addr=0
  - FSM=IDLE, scan counter=0, first_rd flag=1
- BRAM write enable is tied low outside this block; this block never writes.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE:
  - Stays in IDLE while ena=0.
  - Manual mode: go to ISSUE with A=switch when switch != data_addr or first_rd=1.
  - Auto mode: go to ISSUE on scan tick with A=data_addr+1, wrapping 2**ADDR_W-1 -> 0. If first_rd=1, A=0 instead.
- ISSUE (1 cycle):
  - A is latched into mem_addr; mem_en=1; busy=1.
  - Move to WAIT with wait count = RD_LAT-1.
- WAIT:
  - mem_en and mem_addr held stable.
  - Count down; when count reaches 0, go to CAPTURE.
  - With RD_LAT=1, WAIT lasts zero cycles and ISSUE goes straight to CAPTURE.
- CAPTURE (1 cycle):
  - data_out<=mem_dout and data_addr<=mem_addr on the edge ending this cycle.
  - first_rd<=0; mem_en<=0; busy<=0; go to IDLE.
  - data_valid=1 for exactly the following cycle.
- Latency: if ISSUE is cycle T, data_out updates at the end of cycle T+RD_LAT and data_valid is high in cycle T+RD_LAT+1. Back-to-back reads are separated by at least one IDLE cycle.
- Scan counter:
  - Free-runs 0..SCAN_DIV-1 only while mode=1 and ena=1; otherwise it is held at 0.
  - Tick asserts when the count equals SCAN_DIV-1.
  - A tick arriving while not in IDLE is remembered as one pending step; further ticks during the same read are dropped.
- Switch changes during a read are ignored. The mismatch is re-evaluated in IDLE, so the latest switch value wins.
- Mode change mid-read: the read completes; the new mode applies from IDLE. Manual->auto continues from data_addr+1.
- ena deasserted mid-read: the read still completes and data_valid still pulses; no further reads are issued.
- rst mid-read: immediate return to reset values; the in-flight result is discarded.

Optional Feature:
- Macro: MEM_READ_SEQ_HOLD_EN.
- Defined:
  - Adds input port hold (1 bit).
  - While hold=1 in IDLE, no new reads are issued in either mode.
  - The scan counter freezes (keeps its value) and pending steps are cleared.
  - data_out is frozen so the display can be read.
  - Deasserting hold resumes normal operation; manual mode immediately re-checks the switch.
- Undefined: no hold port; behaviour is exactly as above.

Test Plan:
- Reset: rst=1 then 0, ena=1, mode=0, switch=5, mem model returns 0xA0000000+addr with RD_LAT=2.
  - Read issued to addr 5.
  - data_out=0xA0000005, data_addr=5, data_valid pulses in cycle T+3; only one read occurs.
- Manual mode: switch changes 5->2 during WAIT.
  - The first read completes with addr 5.
  - The next ISSUE uses addr 2; data_out=0xA0000002; exactly two data_valid pulses.
- Auto-scan, SCAN_DIV=8, ADDR_W=3, mode=1 from reset:
  - Captured addresses are 0,1,...,7,0 with one capture per 8 cycles.
  - Wrap 7->0 is verified.
- ena low: deassert ena in cycle T+1 of a read.
  - The read completes and data_valid pulses.
  - No mem_en for 50 cycles afterwards; reasserting ena resumes reads.
- Async rst asserted during WAIT (not aligned to clk):
  - Outputs go to 0 before the next edge.
  - No data_valid pulse; after release, a fresh first read is issued.
- MEM_READ_SEQ_HOLD_EN, auto mode:
  - hold=1 for 40 cycles: zero mem_en pulses and data_out unchanged.
  - hold=0: the next capture is data_addr+1.
